// File: rtl/hz_pkg.sv
// Shared types and constants for the hazard scoreboard.
// hz_entry_t describes one in-flight producer; its avail field is sized for
// pipelines of up to 15 tracked stages (select width up to 4 bits).
package hz_pkg;

    localparam int unsigned HZ_AVAIL_W = 4;

    localparam int unsigned HZ_SEL_RF     = 0;
    localparam int unsigned HZ_AVAIL_ALU  = 0;
    localparam int unsigned HZ_AVAIL_LOAD = 1;

    typedef struct packed {
        logic                  valid;
        logic [4:0]            rd;
        logic [HZ_AVAIL_W-1:0] avail;
    } hz_entry_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Handshake bundle between the ID/EX pipeline control and the hazard scoreboard.
// master: pipeline side (drives ID operand info, flush, external stall).
// slave : scoreboard side (drives stall_id, fwd_sel, fwd_sel_ex).
// Optional HAZARD_STATS_EN adds stat_stall_cnt / stat_fwd_cnt.
interface hazard_scoreboard_if #(
    parameter int unsigned NSRC = 2,
    parameter int unsigned SELW = 2
);
    logic                 id_valid;
    logic [NSRC*5-1:0]    id_rs;
    logic [NSRC-1:0]      id_rs_used;
    logic [4:0]           id_rd;
    logic                 id_rd_wen;
    logic [SELW-1:0]      id_avail;
    logic                 flush_ex;
    logic                 stall_ext;
    logic                 stall_id;
    logic [NSRC*SELW-1:0] fwd_sel;
    logic [NSRC*SELW-1:0] fwd_sel_ex;
`ifdef HAZARD_STATS_EN
    logic [31:0]          stat_stall_cnt;
    logic [31:0]          stat_fwd_cnt;
`endif

    modport master (
        output id_valid, id_rs, id_rs_used, id_rd, id_rd_wen, id_avail,
        output flush_ex, stall_ext,
`ifdef HAZARD_STATS_EN
        input  stat_stall_cnt, stat_fwd_cnt,
`endif
        input  stall_id, fwd_sel, fwd_sel_ex
    );

    modport slave (
        input  id_valid, id_rs, id_rs_used, id_rd, id_rd_wen, id_avail,
        input  flush_ex, stall_ext,
`ifdef HAZARD_STATS_EN
        output stat_stall_cnt, stat_fwd_cnt,
`endif
        output stall_id, fwd_sel, fwd_sel_ex
    );
endinterface

// File: rtl/hz_src_check.sv
// Single-operand hazard check against the in-flight entry array.
// Ports: active_i (operand really read, rs != x0), rs_i (source register),
//        entries_i (entry array, index 0 = EX), sel_o (forward select),
//        hazard_o (result not yet available -> stall).
module hz_src_check
    import hz_pkg::*;
#(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned SELW  = 2
) (
    input  logic            active_i,
    input  logic [4:0]      rs_i,
    input  hz_entry_t       entries_i [DEPTH],
    output logic [SELW-1:0] sel_o,
    output logic            hazard_o
);

    logic found;

    // Lowest matching index is the youngest producer and wins.
    always_comb begin
        sel_o    = SELW'(HZ_SEL_RF);
        hazard_o = 1'b0;
        found    = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!found && active_i && entries_i[i].valid && entries_i[i].rd == rs_i) begin
                found = 1'b1;
                if (entries_i[i].avail <= HZ_AVAIL_W'(i)) begin
                    sel_o = SELW'(i + 1);
                end else begin
                    hazard_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Stall/forward controller for the in-order integer pipeline.
// Tracks destination registers of instructions in the DEPTH stages after ID,
// each tagged with the stage at whose end its result exists.
// Ports: clk, rst (async, active-high), bus (hazard_scoreboard_if.slave):
//   in : id_valid, id_rs, id_rs_used, id_rd, id_rd_wen, id_avail, flush_ex, stall_ext
//   out: stall_id, fwd_sel (combinational), fwd_sel_ex (registered)
// Optional macro HAZARD_STATS_EN adds saturating stat_stall_cnt / stat_fwd_cnt.
module hazard_scoreboard
    import hz_pkg::*;
#(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned NSRC  = 2,
    parameter int unsigned SELW  = $clog2(DEPTH + 1)
) (
    input  logic clk,
    input  logic rst,
    hazard_scoreboard_if.slave bus
);

    if (DEPTH < 2) begin : g_depth_chk
        $error("hazard_scoreboard: DEPTH must be >= 2");
    end
    if (SELW > HZ_AVAIL_W) begin : g_selw_chk
        $error("hazard_scoreboard: SELW exceeds hz_entry_t avail width");
    end

    hz_entry_t            entries_q [DEPTH];
    hz_entry_t            entries_d [DEPTH];
    logic [NSRC*SELW-1:0] fwd_sel_c;
    logic [NSRC*SELW-1:0] fwd_sel_ex_q;
    logic [NSRC*SELW-1:0] fwd_sel_ex_d;
    logic [NSRC-1:0]      active;
    logic [NSRC-1:0]      hazard;
    logic                 stall_id_c;
    logic                 enter_ex;
    logic                 advance;

    // One checker per source operand.
    for (genvar s = 0; s < NSRC; s++) begin : g_src
        assign active[s] = bus.id_valid && bus.id_rs_used[s] && (bus.id_rs[5*s +: 5] != 5'd0);

        hz_src_check #(
            .DEPTH (DEPTH),
            .SELW  (SELW)
        ) u_chk (
            .active_i  (active[s]),
            .rs_i      (bus.id_rs[5*s +: 5]),
            .entries_i (entries_q),
            .sel_o     (fwd_sel_c[s*SELW +: SELW]),
            .hazard_o  (hazard[s])
        );
    end

    // Stall/enter decision and next-state of the entry shift register.
    always_comb begin
        advance      = !bus.stall_ext;
        stall_id_c   = (|hazard) && !bus.flush_ex;
        enter_ex     = bus.id_valid && !stall_id_c && !bus.flush_ex;
        entries_d    = entries_q;
        fwd_sel_ex_d = fwd_sel_ex_q;
        if (advance) begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                entries_d[i] = entries_q[i-1];
            end
            entries_d[0] = '0;
            // x0 is never tracked, so it can never be forwarded or stall.
            if (enter_ex && bus.id_rd_wen && bus.id_rd != 5'd0) begin
                entries_d[0].valid = 1'b1;
                entries_d[0].rd    = bus.id_rd;
                entries_d[0].avail = HZ_AVAIL_W'(bus.id_avail);
            end
            fwd_sel_ex_d = enter_ex ? fwd_sel_c : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            fwd_sel_ex_q <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
            fwd_sel_ex_q <= fwd_sel_ex_d;
        end
    end

    assign bus.stall_id   = stall_id_c;
    assign bus.fwd_sel    = fwd_sel_c;
    assign bus.fwd_sel_ex = fwd_sel_ex_q;

`ifdef HAZARD_STATS_EN
    logic [31:0] stat_stall_cnt_q;
    logic [31:0] stat_stall_cnt_d;
    logic [31:0] stat_fwd_cnt_q;
    logic [31:0] stat_fwd_cnt_d;
    logic [31:0] nz_cnt;
    logic [32:0] fwd_sum;

    // Saturating event counters.
    always_comb begin
        nz_cnt = 32'd0;
        for (int unsigned s = 0; s < NSRC; s++) begin
            if (fwd_sel_c[s*SELW +: SELW] != '0) begin
                nz_cnt = nz_cnt + 32'd1;
            end
        end
        stat_stall_cnt_d = stat_stall_cnt_q;
        if (stall_id_c && advance && stat_stall_cnt_q != 32'hFFFF_FFFF) begin
            stat_stall_cnt_d = stat_stall_cnt_q + 32'd1;
        end
        fwd_sum        = 33'(stat_fwd_cnt_q) + 33'(nz_cnt);
        stat_fwd_cnt_d = stat_fwd_cnt_q;
        if (advance && enter_ex) begin
            stat_fwd_cnt_d = fwd_sum[32] ? 32'hFFFF_FFFF : fwd_sum[31:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_stall_cnt_q <= '0;
            stat_fwd_cnt_q   <= '0;
        end else begin
            stat_stall_cnt_q <= stat_stall_cnt_d;
            stat_fwd_cnt_q   <= stat_fwd_cnt_d;
        end
    end

    assign bus.stat_stall_cnt = stat_stall_cnt_q;
    assign bus.stat_fwd_cnt   = stat_fwd_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed pipeline scenarios
// followed by randomized traffic, checked against a queue-of-producers model.
module tb_hazard_scoreboard;

    localparam int unsigned DEPTH = 3;
    localparam int unsigned NSRC  = 2;
    localparam int unsigned SELW  = $clog2(DEPTH + 1);
    localparam int unsigned SW    = NSRC * SELW;

    logic clk;
    logic rst;

    hazard_scoreboard_if #(.NSRC(NSRC), .SELW(SELW)) bus ();

    hazard_scoreboard #(
        .DEPTH (DEPTH),
        .NSRC  (NSRC),
        .SELW  (SELW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // In-flight producer: youngest at the front of the queue.
    typedef struct {
        logic [4:0] rd;
        int         avail;
        int         stage;
    } rec_t;

    typedef struct {
        logic          stall;
        logic [SW-1:0] sel;
        logic [SW-1:0] sel_ex;
        int            cyc;
    } exp_t;

    rec_t inflight[$];
    exp_t expq[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Inputs applied for the current cycle and those of the previous cycle.
    logic          c_rst, c_v, c_wen, c_fl, c_se;
    logic [4:0]    c_rs0, c_rs1, c_rd;
    logic [1:0]    c_used;
    int            c_av;
    logic          p_rst = 1'b1, p_se = 1'b0, p_en = 1'b0, p_wen = 1'b0;
    logic [4:0]    p_rd = '0;
    int            p_av = 0;
    logic [SW-1:0] p_sel = '0;
    logic [SW-1:0] m_sel_ex = '0;

    // Apply the effect of the clock edge using the inputs seen before it.
    task automatic model_edge();
        if (!p_rst && !p_se) begin
            for (int k = 0; k < inflight.size(); k++) inflight[k].stage++;
            while (inflight.size() > 0 && inflight[inflight.size()-1].stage >= int'(DEPTH))
                void'(inflight.pop_back());
            if (p_en && p_wen && p_rd != 5'd0) begin
                rec_t r;
                r.rd = p_rd; r.avail = p_av; r.stage = 0;
                inflight.push_front(r);
            end
            m_sel_ex = p_en ? p_sel : '0;
        end
    endtask

    // Expected combinational response for the current inputs.
    task automatic model_eval(output logic st, output logic [SW-1:0] sl, output logic en);
        logic       haz;
        logic [4:0] rs;
        haz = 1'b0;
        sl  = '0;
        for (int s = 0; s < int'(NSRC); s++) begin
            rs = (s == 0) ? c_rs0 : c_rs1;
            if (c_v && c_used[s] && rs != 5'd0) begin
                for (int k = 0; k < inflight.size(); k++) begin
                    if (inflight[k].rd == rs) begin
                        if (inflight[k].avail <= inflight[k].stage)
                            sl[s*SELW +: SELW] = SELW'(inflight[k].stage + 1);
                        else
                            haz = 1'b1;
                        break;
                    end
                end
            end
        end
        st = haz && !c_fl;
        en = c_v && !st && !c_fl;
    endtask

    task automatic step(input logic r, input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                        input logic [1:0] used, input logic [4:0] rd, input logic wen,
                        input int av, input logic fl, input logic se);
        exp_t          e;
        logic          st, en;
        logic [SW-1:0] sl;
        @(posedge clk);
        #1;
        cyc++;
        model_edge();
        c_rst = r; c_v = v; c_rs0 = rs0; c_rs1 = rs1; c_used = used;
        c_rd = rd; c_wen = wen; c_av = av; c_fl = fl; c_se = se;
        rst            = r;
        bus.id_valid   = v;
        bus.id_rs      = {rs1, rs0};
        bus.id_rs_used = used;
        bus.id_rd      = rd;
        bus.id_rd_wen  = wen;
        bus.id_avail   = SELW'(av);
        bus.flush_ex   = fl;
        bus.stall_ext  = se;
        if (r) begin
            inflight.delete();
            m_sel_ex = '0;
        end
        model_eval(st, sl, en);
        p_rst = r; p_se = se; p_en = en; p_wen = wen; p_rd = rd; p_av = av; p_sel = sl;
        e.stall = st; e.sel = sl; e.sel_ex = m_sel_ex; e.cyc = cyc;
        expq.push_back(e);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    // Monitor: compare DUT outputs mid-cycle against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                checks++;
                if (bus.stall_id !== e.stall) begin
                    errors++;
                    $display("FAIL stall_id cyc=%0d got=%0b exp=%0b", e.cyc, bus.stall_id, e.stall);
                end
                checks++;
                if (bus.fwd_sel !== e.sel) begin
                    errors++;
                    $display("FAIL fwd_sel cyc=%0d got=%0h exp=%0h", e.cyc, bus.fwd_sel, e.sel);
                end
                checks++;
                if (bus.fwd_sel_ex !== e.sel_ex) begin
                    errors++;
                    $display("FAIL fwd_sel_ex cyc=%0d got=%0h exp=%0h", e.cyc, bus.fwd_sel_ex, e.sel_ex);
                end
            end
        end
    end

    initial begin
        rst            = 1'b1;
        bus.id_valid   = 1'b0;
        bus.id_rs      = '0;
        bus.id_rs_used = '0;
        bus.id_rd      = '0;
        bus.id_rd_wen  = 1'b0;
        bus.id_avail   = '0;
        bus.flush_ex   = 1'b0;
        bus.stall_ext  = 1'b0;

        // Reset state.
        step(1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 5'd5, 5'd6, 2'b11, 5'd0, 1'b0, 0, 1'b0, 1'b0);
        idle();

        // Back-to-back ALU dependency.
        step(1'b0, 1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 5'd5, 5'd0, 2'b01, 5'd0, 1'b0, 0, 1'b0, 1'b0);
        idle(); idle(); idle();

        // Load-use: one stall, then forward from stage 1.
        step(1'b0, 1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 5'd7, 5'd0, 2'b01, 5'd8, 1'b1, 0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 5'd7, 5'd0, 2'b01, 5'd8, 1'b1, 0, 1'b0, 1'b0);
        idle(); idle(); idle();

        // Two producers of x3, youngest wins.
        step(1'b0, 1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 5'd0, 5'd3, 2'b10, 5'd0, 1'b0, 0, 1'b0, 1'b0);
        idle(); idle(); idle();

        // x0 producer and consumer.
        step(1'b0, 1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 5'd0, 5'd0, 2'b11, 5'd0, 1'b0, 0, 1'b0, 1'b0);
        idle(); idle(); idle();

        // Load-use coinciding with flush.
        step(1'b0, 1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 5'd7, 5'd0, 2'b01, 5'd9, 1'b1, 0, 1'b1, 1'b0);
        idle(); idle(); idle();

        // External stall held three cycles during load-use.
        step(1'b0, 1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 5'd7, 5'd0, 2'b01, 5'd0, 1'b0, 0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 5'd7, 5'd0, 2'b01, 5'd0, 1'b0, 0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 5'd7, 5'd0, 2'b01, 5'd0, 1'b0, 0, 1'b0, 1'b0);
        idle(); idle(); idle();

        // Reset with three valid entries in flight.
        step(1'b0, 1'b1, 5'd0, 5'd0, 2'b00, 5'd1, 1'b1, 2, 1'b0, 1'b0);
        step(1'b0, 1'b1, 5'd0, 5'd0, 2'b00, 5'd2, 1'b1, 1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 5'd1, 5'd2, 2'b00, 5'd4, 1'b1, 0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 5'd1, 5'd4, 2'b11, 5'd0, 1'b0, 0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 5'd1, 5'd4, 2'b11, 5'd0, 1'b0, 0, 1'b0, 1'b0);

        // Randomized traffic over a small register set to force collisions.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 7) != 0),
                 5'($urandom_range(0, 6)), 5'($urandom_range(0, 6)),
                 2'($urandom_range(0, 3)),
                 5'($urandom_range(0, 6)),
                 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, DEPTH - 1)),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 6) == 0));
        end

        repeat (4) @(negedge clk);
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
